// File: rtl/mpeg2_seq_ctrl_if.sv
// rtl/mpeg2_seq_ctrl_if.sv - pixel source stream and mpeg2encoder core bundle for the sequencer
interface mpeg2_seq_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        enc_rstn;
  logic [6:0]  enc_xsize16;
  logic [6:0]  enc_ysize16;
  logic        enc_i_en;
  logic [63:0] enc_i_data;
  logic        enc_seq_stop;
  logic        enc_seq_busy;

  // slave: the sequencer; master: pixel source plus encoder core around it
  modport slave (
    input  s_valid, s_data, enc_seq_busy,
    output s_ready, enc_rstn, enc_xsize16, enc_ysize16, enc_i_en, enc_i_data, enc_seq_stop
  );
  modport master (
    output s_valid, s_data, enc_seq_busy,
    input  s_ready, enc_rstn, enc_xsize16, enc_ysize16, enc_i_en, enc_i_data, enc_seq_stop
  );
endinterface

// File: rtl/mpeg2_seq_ctrl.sv
// rtl/mpeg2_seq_ctrl.sv - resets the mpeg2encoder core, feeds N frames of pixel beats, stops and drains it
module mpeg2_seq_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int DRAIN_MAX  = 1048576
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic [6:0]  cmd_xsize16,
  input  logic [6:0]  cmd_ysize16,
  input  logic [15:0] cmd_nframes,
  mpeg2_seq_ctrl_if.slave io,
  output logic        busy,
  output logic        done,
  output logic        err_cfg,
  output logic        err_timeout,
  output logic [15:0] frame_cnt
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {IDLE, RST, FEED, STOP, DRAIN} state_t;
  state_t state, state_nx;

  logic [RW-1:0] rst_cnt;
  logic [DW-1:0] drain_cnt;
  logic [19:0]   beat_cnt;
  logic [19:0]   beats_m1;
  logic [15:0]   nframes;
  logic [6:0]    xsize_q, ysize_q;
  logic          enc_rstn_q, enc_i_en_q, enc_seq_stop_q;
  logic [63:0]   enc_i_data_q;

  logic cfg_ok, accept, last_beat, last_frame, rst_end, drain_ok, drain_to, s_ready_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    s_ready_c  = (state == FEED);
    busy       = (state != IDLE);
    cfg_ok     = (cmd_xsize16 != 7'd0) && (cmd_ysize16 != 7'd0) && (cmd_nframes != 16'd0);
    accept     = (state == FEED) && io.s_valid;
    last_beat  = (beat_cnt == beats_m1);
    last_frame = (frame_cnt == nframes - 16'd1);
    rst_end    = (rst_cnt == RW'(RST_CYCLES - 1));
    // The first two drain cycles are skipped: the core needs time to raise busy after stop.
    drain_ok   = (drain_cnt > DW'(1)) && !io.enc_seq_busy;
    drain_to   = !drain_ok && (drain_cnt == DW'(DRAIN_MAX - 1));
    case (state)
      IDLE:    if (cmd_start && cfg_ok) state_nx = RST;
      RST:     if (cmd_abort) state_nx = IDLE;
               else if (rst_end) state_nx = FEED;
      FEED:    if (cmd_abort || (accept && last_beat && last_frame)) state_nx = STOP;
      STOP:    state_nx = DRAIN;
      DRAIN:   if (drain_ok || drain_to) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_cnt        <= '0;
      drain_cnt      <= '0;
      beat_cnt       <= '0;
      beats_m1       <= '0;
      nframes        <= '0;
      xsize_q        <= '0;
      ysize_q        <= '0;
      frame_cnt      <= '0;
      enc_rstn_q     <= 1'b0;
      enc_i_en_q     <= 1'b0;
      enc_i_data_q   <= '0;
      enc_seq_stop_q <= 1'b0;
      done           <= 1'b0;
      err_cfg        <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      done           <= 1'b0;
      enc_seq_stop_q <= 1'b0;
      enc_i_en_q     <= accept;
      if (accept) enc_i_data_q <= io.s_data;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            if (!cfg_ok) begin
              err_cfg <= 1'b1;
              done    <= 1'b1;
            end else begin
              xsize_q     <= cmd_xsize16;
              ysize_q     <= cmd_ysize16;
              nframes     <= cmd_nframes;
              beats_m1    <= {14'(cmd_xsize16) * 14'(cmd_ysize16), 6'd0} - 20'd1;
              err_cfg     <= 1'b0;
              err_timeout <= 1'b0;
              frame_cnt   <= '0;
              beat_cnt    <= '0;
              rst_cnt     <= '0;
              enc_rstn_q  <= 1'b0;
            end
          end
        end
        RST: begin
          rst_cnt <= rst_cnt + RW'(1);
          if (cmd_abort)    done       <= 1'b1;
          else if (rst_end) enc_rstn_q <= 1'b1;
        end
        FEED: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            end else begin
              beat_cnt <= beat_cnt + 20'd1;
            end
          end
        end
        // Stop is registered here so it lands one cycle after the final enc_i_en.
        STOP: begin
          enc_seq_stop_q <= 1'b1;
          drain_cnt      <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_ok) done <= 1'b1;
          else if (drain_to) begin
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.s_ready      = s_ready_c;
  assign io.enc_rstn     = enc_rstn_q;
  assign io.enc_xsize16  = xsize_q;
  assign io.enc_ysize16  = ysize_q;
  assign io.enc_i_en     = enc_i_en_q;
  assign io.enc_i_data   = enc_i_data_q;
  assign io.enc_seq_stop = enc_seq_stop_q;
endmodule

// File: tb/tb_mpeg2_seq_ctrl.sv
// tb/tb_mpeg2_seq_ctrl.sv - scoreboard bench for mpeg2_seq_ctrl with randomized pixel source and core model
module tb_mpeg2_seq_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_start, cmd_abort;
  logic [6:0]  cmd_xsize16, cmd_ysize16;
  logic [15:0] cmd_nframes;
  logic        busy, done, err_cfg, err_timeout;
  logic [15:0] frame_cnt;

  mpeg2_seq_ctrl_if ifc();

  mpeg2_seq_ctrl #(.RST_CYCLES(16), .DRAIN_MAX(64)) dut (
    .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_xsize16(cmd_xsize16), .cmd_ysize16(cmd_ysize16), .cmd_nframes(cmd_nframes),
    .io(ifc.slave), .busy(busy), .done(done), .err_cfg(err_cfg),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc = 0, en_cnt = 0, stop_cnt = 0, stop_cyc = 0, last_en_cyc = 0;
  logic [63:0] exp_q[$];
  bit busy_stuck = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every enc_i_en beat must match the oldest beat the source handed over.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (ifc.enc_i_en) begin
          en_cnt++;
          last_en_cyc = cyc;
          if (exp_q.size() == 0) chk("spurious_enc_i_en", ifc.enc_i_en, 0);
          else begin
            e = exp_q.pop_front();
            chk("enc_i_data", ifc.enc_i_data, e);
          end
        end
        if (ifc.enc_seq_stop) begin
          stop_cnt++;
          stop_cyc = cyc;
          chk("stop_overlaps_en", ifc.enc_i_en, 0);
        end
      end
    end
  end

  // Core model: busy rises with the first pixel, falls a few cycles after stop unless stuck.
  initial begin
    int  drain_left = 0;
    bit  draining = 0;
    ifc.enc_seq_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.enc_i_en) ifc.enc_seq_busy = 1'b1;
      if (ifc.enc_seq_stop) begin
        draining   = 1;
        drain_left = $urandom_range(0, 8);
      end else if (draining) begin
        if (drain_left > 0) drain_left--;
        else if (!busy_stuck) begin
          ifc.enc_seq_busy = 1'b0;
          draining = 0;
        end
      end
    end
  end

  task automatic chk_reset();
    chk("rst_enc_rstn", ifc.enc_rstn, 0);
    chk("rst_s_ready", ifc.s_ready, 0);
    chk("rst_enc_i_en", ifc.enc_i_en, 0);
    chk("rst_enc_seq_stop", ifc.enc_seq_stop, 0);
    chk("rst_enc_i_data", ifc.enc_i_data, 0);
    chk("rst_enc_xsize16", ifc.enc_xsize16, 0);
    chk("rst_enc_ysize16", ifc.enc_ysize16, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
  endtask

  // stop_at >= 0 cuts the run after that many accepted beats, by abort or by rstn.
  task automatic run(input int x, input int y, input int n, input int vpct,
                     input int stop_at, input bit do_reset, input bit stuck);
    int bpf, total, target, pushed, en0, stop0, guard, rlow;
    bpf    = x * y * 64;
    total  = bpf * n;
    target = (stop_at >= 0 && stop_at < total) ? stop_at : total;
    pushed = 0;
    busy_stuck = stuck;
    en0   = en_cnt;
    stop0 = stop_cnt;
    @(negedge clk);
    cmd_xsize16 = 7'(x);
    cmd_ysize16 = 7'(y);
    cmd_nframes = 16'(n);
    cmd_start   = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    rlow = 0;
    while (!ifc.enc_rstn && rlow < 100) begin
      rlow++;
      @(negedge clk);
    end
    chk("enc_rstn_low_cycles", rlow, 16);
    chk("enc_xsize16", ifc.enc_xsize16, x);
    chk("enc_ysize16", ifc.enc_ysize16, y);
    guard = 0;
    while (pushed < target && guard < 20000) begin
      ifc.s_valid = ($urandom_range(0, 99) < vpct);
      ifc.s_data  = {$urandom, $urandom};
      if (ifc.s_valid && ifc.s_ready) begin
        exp_q.push_back(ifc.s_data);
        pushed++;
      end
      @(negedge clk);
      guard++;
    end
    ifc.s_valid = 1'b0;
    chk("feed_within_budget", pushed, target);
    if (target < total && do_reset) begin
      rstn = 1'b0;
      #1;
      exp_q.delete();
      chk_reset();
      @(negedge clk);
      rstn = 1'b1;
      busy_stuck = 0;
      return;
    end
    if (target < total) begin
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
    end
    guard = 0;
    while (!done && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("done_seen", done, 1);
    chk("busy_after_done", busy, 0);
    chk("frame_cnt", frame_cnt, target / bpf);
    chk("enc_i_en_count", en_cnt - en0, target);
    chk("stop_count", stop_cnt - stop0, 1);
    chk("err_timeout", err_timeout, stuck);
    chk("err_cfg", err_cfg, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    if (target == total) chk("stop_after_last_en", stop_cyc - last_en_cyc, 1);
    if (stuck) chk("timeout_latency", cyc - stop_cyc, 64);
    @(negedge clk);
    chk("done_single_cycle", done, 0);
    busy_stuck = 0;
  endtask

  initial begin
    logic r0;
    rstn = 1'b0;
    cmd_start = 1'b0; cmd_abort = 1'b0;
    cmd_xsize16 = '0; cmd_ysize16 = '0; cmd_nframes = '0;
    ifc.s_valid = 1'b0; ifc.s_data = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run(2, 1, 2, 100, -1, 0, 0);
    run(2, 1, 2, 50, -1, 0, 0);

    r0 = ifc.enc_rstn;
    @(negedge clk);
    cmd_xsize16 = 7'd2; cmd_ysize16 = 7'd0; cmd_nframes = 16'd1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("cfg_done", done, 1);
    chk("cfg_err", err_cfg, 1);
    chk("cfg_busy", busy, 0);
    chk("cfg_enc_rstn", ifc.enc_rstn, r0);
    @(negedge clk);
    chk("cfg_done_pulse", done, 0);
    chk("cfg_err_sticky", err_cfg, 1);
    chk("cfg_still_idle", busy, 0);

    run(2, 1, 2, 80, 100, 0, 0);
    run(1, 1, 1, 100, -1, 0, 1);
    run(2, 1, 1, 70, 50, 1, 0);
    run(1, 1, 2, 60, -1, 0, 0);
    for (int i = 0; i < 3; i++)
      run($urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 3),
          $urandom_range(30, 100), -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
